// File: rtl/alu_ctrl_pkg.sv
// Shared types and default constants for the sequenced ALU control block.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OPC_ADD = 3'b000,
    OPC_SUB = 3'b001,
    OPC_AND = 3'b010,
    OPC_OR  = 3'b011,
    OPC_SHL = 3'b100,
    OPC_SHR = 3'b101,
    OPC_BNE = 3'b110,
    OPC_XOR = 3'b111
  } alu_opc_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    REPEAT = 2'd2
  } alu_ctrl_state_e;

  localparam logic [2:0] BR_OPC_DEFAULT     = OPC_BNE;
  localparam logic [7:0] MULTI_MASK_DEFAULT = 8'b0011_0000;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of (alu_op, branch, instruction) into an ALU opcode
// and the number of single-step beats that opcode expands into.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int                    INSTR_W    = 9,
  parameter int                    OPC_W      = 3,
  parameter int                    FUNC_LSB   = 4,
  parameter int                    CNT_W      = 3,
  parameter logic [OPC_W-1:0]      BR_OPC     = BR_OPC_DEFAULT,
  parameter logic [2**OPC_W-1:0]   MULTI_MASK = MULTI_MASK_DEFAULT
) (
  input  logic               alu_op,
  input  logic               branch,
  input  logic [INSTR_W-1:0] instruction,
  output logic [OPC_W-1:0]   opc,
  output logic [CNT_W-1:0]   n
);

  logic [OPC_W-1:0]      field;
  logic [CNT_W-1:0]      cnt_field;
  logic [2**OPC_W-1:0]   multi_hit;
  logic                  is_multi;
  logic                  unused_instr_bits;

  assign field     = instruction[FUNC_LSB+OPC_W-1:FUNC_LSB];
  assign cnt_field = instruction[CNT_W-1:0];
  // Bits outside the opcode and count fields carry no meaning here.
  assign unused_instr_bits = ^instruction;

  genvar gi;
  generate
    for (gi = 0; gi < 2**OPC_W; gi++) begin : g_multi
      assign multi_hit[gi] = MULTI_MASK[gi] && (field == OPC_W'(gi));
    end
  endgenerate

  assign is_multi = |multi_hit;

  always_comb begin
    opc = '0;
    n   = CNT_W'(1);
    if (alu_op) begin
      if (branch) begin
        opc = BR_OPC;
      end else begin
        opc = field;
        // A zero count still issues the operation once.
        if (is_multi && (cnt_field != '0)) n = cnt_field;
      end
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU control: expands iterative ops into single-step beats with
// valid/ready on both sides. Define ALU_CTRL_STATS_EN for beat/stall counters.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int                    INSTR_W    = 9,
  parameter int                    OPC_W      = 3,
  parameter int                    FUNC_LSB   = 4,
  parameter int                    CNT_W      = 3,
  parameter logic [OPC_W-1:0]      BR_OPC     = BR_OPC_DEFAULT,
  parameter logic [2**OPC_W-1:0]   MULTI_MASK = MULTI_MASK_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               alu_op,
  input  logic               branch,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic               iter_last,
  output logic               busy
`ifdef ALU_CTRL_STATS_EN
  ,
  output logic [15:0]        beat_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  logic [OPC_W-1:0] dec_opc;
  logic [CNT_W-1:0] dec_n;

  alu_ctrl_state_e  state_reg;
  logic [OPC_W-1:0] opcode_reg;
  logic [CNT_W-1:0] remain_reg;
  logic             last_beat;
  logic             accept;
  logic             beat;

  alu_ctrl_decode #(
    .INSTR_W   (INSTR_W),
    .OPC_W     (OPC_W),
    .FUNC_LSB  (FUNC_LSB),
    .CNT_W     (CNT_W),
    .BR_OPC    (BR_OPC),
    .MULTI_MASK(MULTI_MASK)
  ) u_decode (
    .alu_op     (alu_op),
    .branch     (branch),
    .instruction(instruction),
    .opc        (dec_opc),
    .n          (dec_n)
  );

  assign out_valid  = (state_reg != IDLE);
  assign busy       = out_valid;
  assign alu_opcode = opcode_reg;
  assign last_beat  = out_valid && (remain_reg == CNT_W'(1));
  assign iter_last  = last_beat;
  // Accepting during the final beat keeps the ALU stream bubble-free.
  assign in_ready   = rst_n && (!out_valid || (out_ready && last_beat));
  assign accept     = in_valid && in_ready;
  assign beat       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      opcode_reg <= '0;
      remain_reg <= '0;
    end else if (accept) begin
      state_reg  <= ISSUE;
      opcode_reg <= dec_opc;
      remain_reg <= dec_n;
    end else if (beat) begin
      if (remain_reg == CNT_W'(1)) begin
        state_reg  <= IDLE;
        remain_reg <= '0;
      end else begin
        state_reg  <= REPEAT;
        remain_reg <= remain_reg - CNT_W'(1);
      end
    end
  end

`ifdef ALU_CTRL_STATS_EN
  logic [15:0] beat_cnt_reg;
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (beat && (beat_cnt_reg != 16'hFFFF)) beat_cnt_reg <= beat_cnt_reg + 16'd1;
      if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign beat_cnt  = beat_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq (works with or without
// ALU_CTRL_STATS_EN defined).
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       alu_op;
  logic       branch;
  logic [8:0] instruction;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] alu_opcode;
  logic       iter_last;
  logic       busy;
`ifdef ALU_CTRL_STATS_EN
  logic [15:0] beat_cnt;
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .branch     (branch),
    .instruction(instruction),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_opcode (alu_opcode),
    .iter_last  (iter_last),
    .busy       (busy)
`ifdef ALU_CTRL_STATS_EN
    ,
    .beat_cnt   (beat_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  // Present one op from an idle slot; returns in the slot after acceptance
  // with in_valid dropped.
  task automatic drive_op(input logic a, input logic b, input logic [8:0] instr);
    int waited;
    in_valid    = 1'b1;
    alu_op      = a;
    branch      = b;
    instruction = instr;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      next_slot();
      #1;
      waited++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL drive_op_timeout: in_ready=%0b required=1", in_ready);
    end
    next_slot();
    in_valid    = 1'b0;
    instruction = 9'h1FF;
  endtask

  // Run cycles with a given out_ready pattern and gather what the ALU saw.
  task automatic collect(input logic [15:0] pat, input logic [2:0] exp_opc,
                         output int beats, output int wrong_opc,
                         output int last_cnt, output int last_idx,
                         output int stalls);
    beats = 0; wrong_opc = 0; last_cnt = 0; last_idx = 0; stalls = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = pat[c];
      #1;
      if (out_valid) begin
        if (alu_opcode !== exp_opc) wrong_opc++;
        if (out_ready) begin
          beats++;
          if (iter_last) begin
            last_cnt++;
            last_idx = beats;
          end
        end else begin
          stalls++;
        end
      end
      next_slot();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 1'b0; branch = 1'b0;
    instruction = '0; out_ready = 1'b1;
    next_slot();
    next_slot();
    total++;
    if ({out_valid, alu_opcode, iter_last, in_ready, busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state: v=%0b opc=%0b last=%0b rdy=%0b busy=%0b required all 0",
               out_valid, alu_opcode, iter_last, in_ready, busy);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: in_ready=%0b required=1", in_ready);
    end
    next_slot();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_op(1'b1, 1'b0, 9'b0_010_0000);
    #1;
    total++;
    if ({out_valid, busy, alu_opcode, iter_last, in_ready} !== 7'b11_010_1_1) begin
      bad++;
      $display("FAIL single_beat: v=%0b busy=%0b opc=%0b last=%0b rdy=%0b required v=1 busy=1 opc=010 last=1 rdy=1",
               out_valid, busy, alu_opcode, iter_last, in_ready);
    end
    next_slot();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_done: v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_branch();
    int beats, wrong, lastc, lasti, stalls;
    drive_op(1'b1, 1'b1, 9'b0_100_0011);
    collect(16'hFFFF, 3'b110, beats, wrong, lastc, lasti, stalls);
    total++;
    if (beats != 1 || wrong != 0 || lastc != 1) begin
      bad++;
      $display("FAIL branch_override: beats=%0d wrong_opc=%0d last=%0d required 1/0/1", beats, wrong, lastc);
    end
    drive_op(1'b0, 1'b0, 9'b0_101_0011);
    collect(16'hFFFF, 3'b000, beats, wrong, lastc, lasti, stalls);
    total++;
    if (beats != 1 || wrong != 0 || lastc != 1) begin
      bad++;
      $display("FAIL passthrough: beats=%0d wrong_opc=%0d last=%0d required 1/0/1", beats, wrong, lastc);
    end
  endtask

  task automatic test_shift_stall();
    int beats, wrong, lastc, lasti, stalls;
    drive_op(1'b1, 1'b0, 9'b0_100_0011);
    collect(16'hFFF5, 3'b100, beats, wrong, lastc, lasti, stalls);
    total++;
    if (beats != 3 || wrong != 0 || stalls != 2) begin
      bad++;
      $display("FAIL shift3_beats: beats=%0d wrong_opc=%0d stalls=%0d required 3/0/2", beats, wrong, stalls);
    end
    total++;
    if (lastc != 1 || lasti != 3) begin
      bad++;
      $display("FAIL shift3_last: last_cnt=%0d last_idx=%0d required 1/3", lastc, lasti);
    end
`ifdef ALU_CTRL_STATS_EN
    // Six beats and two stall cycles so far since reset.
    total++;
    if (beat_cnt !== 16'd6 || stall_cnt !== 16'd2) begin
      bad++;
      $display("FAIL stats_counts: beat_cnt=%0d stall_cnt=%0d required 6/2", beat_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_count0();
    int beats, wrong, lastc, lasti, stalls;
    drive_op(1'b1, 1'b0, 9'b0_100_0000);
    collect(16'hFFFF, 3'b100, beats, wrong, lastc, lasti, stalls);
    total++;
    if (beats != 1 || wrong != 0 || lastc != 1) begin
      bad++;
      $display("FAIL count0: beats=%0d wrong_opc=%0d last=%0d required 1/0/1", beats, wrong, lastc);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_op(1'b1, 1'b0, 9'b0_101_0010);
    next_slot();
    in_valid = 1'b1; alu_op = 1'b1; branch = 1'b0; instruction = 9'b0_001_0000;
    #1;
    total++;
    if (out_valid !== 1'b1 || iter_last !== 1'b1 || in_ready !== 1'b1 || alu_opcode !== 3'b101) begin
      bad++;
      $display("FAIL b2b_accept: v=%0b last=%0b rdy=%0b opc=%0b required 1/1/1/101",
               out_valid, iter_last, in_ready, alu_opcode);
    end
    next_slot();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || alu_opcode !== 3'b001 || iter_last !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: v=%0b opc=%0b last=%0b required 1/001/1", out_valid, alu_opcode, iter_last);
    end
    next_slot();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done: v=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    out_ready = 1'b1;
    drive_op(1'b1, 1'b0, 9'b0_101_0101);
    next_slot();
    next_slot();
    total++;
    if (out_valid !== 1'b1 || alu_opcode !== 3'b101 || iter_last !== 1'b0) begin
      bad++;
      $display("FAIL mid_before_reset: v=%0b opc=%0b last=%0b required 1/101/0", out_valid, alu_opcode, iter_last);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || alu_opcode !== 3'b000 || in_ready !== 1'b0 || iter_last !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: v=%0b opc=%0b rdy=%0b last=%0b required 0/000/0/0",
               out_valid, alu_opcode, in_ready, iter_last);
    end
    next_slot();
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_release: rdy=%0b v=%0b required 1/0", in_ready, out_valid);
    end
`ifdef ALU_CTRL_STATS_EN
    total++;
    if (beat_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL stats_reset: beat_cnt=%0d stall_cnt=%0d required 0/0", beat_cnt, stall_cnt);
    end
`endif
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      next_slot();
      if (out_valid) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL mid_stale_beats: stale=%0d required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_branch();
    test_shift_stall();
    test_count0();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
